axil_reg_slave: RTL and testbench

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

---
 rtl/axil_reg_slave.sv | 166 ++++++++++++++++
 tb/tb_axil_reg_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder exposing four 32-bit read/write registers.
// Define AXIL_REG_SLVERR_EN to answer out-of-range addresses with SLVERR.
module axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          live;
  logic          aw_held;
  logic          w_held;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic [DW-1:0] regs [4];
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [1:0]    wr_idx;
  logic [1:0]    rd_idx;
  logic          wr_err;
  logic          rd_err;
  logic          unused_bits;

  // ready lines depend only on state; live keeps them low until the
  // first edge after reset release
  assign S_AXI_AWREADY = live & ~aw_held & ~bvalid_q;
  assign S_AXI_WREADY  = live & ~w_held & ~bvalid_q;
  assign S_AXI_ARREADY = live & ~rvalid_q;

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);

  assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
  assign wr_idx  = wr_addr[3:2];
  assign rd_idx  = S_AXI_ARADDR[3:2];

`ifdef AXIL_REG_SLVERR_EN
  assign wr_err = |(wr_addr >> 4);
  assign rd_err = |(S_AXI_ARADDR >> 4);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         wr_addr, S_AXI_ARADDR};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && !wr_err) begin
      for (int b = 0; b < SW; b++) begin
        if (wr_strb[b]) begin
          regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_err ? SLVERR : OKAY;
    end else if (S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // regs is sampled before the same-edge write lands: old value wins
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_err ? SLVERR : OKAY;
      rdata_q  <= rd_err ? '0 : regs[rd_idx];
    end else if (S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave (5-bit address build).
// Expected B/R responses are queued by stimulus and checked by a monitor.
module tb_axil_reg_slave;
  localparam int AW = 5;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;

  int n_checks = 0;
  int n_pass = 0;

  logic [1:0]  exp_b[$];
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_rr[$];

  always #5 ACLK = ~ACLK;

  axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // monitor: a response is consumed when valid & ready at the next edge
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected", 32'(bvalid), 32'd0);
        end else begin
          chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
        end
      end
      if (rvalid && rready) begin
        if (exp_rd.size() == 0) begin
          chk("r_unexpected", 32'(rvalid), 32'd0);
        end else begin
          chk("rdata", rdata, exp_rd.pop_front());
          chk("rresp", 32'(rresp), 32'(exp_rr.pop_front()));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bvalid || rvalid) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk({name, "_tmo"}, 32'(bvalid | rvalid), 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          input logic [1:0] resp);
    int n = 0;
    exp_b.push_back(resp);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("wr_ready_tmo", 32'(awready & wready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_lat1", 32'(bvalid), 32'd1);
    wait_idle("wr");
  endtask

  task automatic do_read(input logic [AW-1:0] a,
                         input logic [31:0] d,
                         input logic [1:0] resp);
    int n = 0;
    exp_rd.push_back(d);
    exp_rr.push_back(resp);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ar_ready_tmo", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_lat", 32'(rvalid), 32'd1);
    wait_idle("rd");
  endtask

  initial begin
    #100;
    chk("rst_rdy", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_val", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    #100;
    ARESETN = 1'b1;
    #1;
    chk("rdy_pre_edge", {29'd0, awready, wready, arready}, 32'd0);
    tick();
    chk("rdy_post_edge", {29'd0, awready, wready, arready}, 32'd7);

    for (int i = 0; i < 4; i++) do_read(AW'(4 * i), 32'd0, 2'b00);

    for (int i = 0; i < 4; i++) do_write(AW'(4 * i), 32'(i + 1), 4'hF, 2'b00);
    for (int i = 0; i < 4; i++) do_read(AW'(4 * i), 32'(i + 1), 2'b00);

    do_write(5'h0C, 32'hFFFF_FFFF, 4'h0, 2'b00);
    do_read(5'h0C, 32'd4, 2'b00);
    do_read(5'h0D, 32'd4, 2'b00);

    // W three cycles ahead of AW, partial strobes
    do_write(5'h08, 32'h1122_3344, 4'hF, 2'b00);
    exp_b.push_back(2'b00);
    wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("w_held", {30'd0, wready, awready}, 32'd1);
    tick();
    tick();
    chk("no_b_w_only", 32'(bvalid), 32'd0);
    awaddr = 5'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("b_on_aw_edge", 32'(bvalid), 32'd1);
    wait_idle("ooo");
    do_read(5'h08, 32'h11BB_33DD, 2'b00);

    // read/write collision on reg 1 with B backpressure
    bready = 1'b0;
    exp_b.push_back(2'b00);
    exp_rd.push_back(32'd2);
    exp_rr.push_back(2'b00);
    araddr = 5'h04; arvalid = 1'b1;
    awaddr = 5'h04; awvalid = 1'b1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {29'd0, bvalid, awready, wready}, 32'd4);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("bp_release", 32'(bvalid), 32'd0);
    do_read(5'h04, 32'hDEAD_BEEF, 2'b00);

    // reset while R pending and AW held
    rready = 1'b0;
    araddr = 5'h00; arvalid = 1'b1;
    awaddr = 5'h0C; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    chk("pre_rst_state", {29'd0, rvalid, awready, wready}, 32'd5);
    #3;
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_val", {30'd0, rvalid, bvalid}, 32'd0);
    chk("mid_rst_rdy", {29'd0, awready, wready, arready}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    tick();
    tick();
    ARESETN = 1'b1;
    rready = 1'b1;
    tick();
    chk("aw_held_cleared", {29'd0, awready, wready, arready}, 32'd7);
    tick();
    chk("no_stale_resp", {30'd0, rvalid, bvalid}, 32'd0);
    for (int i = 0; i < 4; i++) do_read(AW'(4 * i), 32'd0, 2'b00);

`ifdef AXIL_REG_SLVERR_EN
    do_write(5'h10, 32'hCAFE_F00D, 4'hF, 2'b10);
    do_read(5'h00, 32'd0, 2'b00);
    do_read(5'h10, 32'd0, 2'b10);
`else
    do_write(5'h10, 32'hCAFE_F00D, 4'hF, 2'b00);
    do_read(5'h00, 32'hCAFE_F00D, 2'b00);
    do_read(5'h10, 32'hCAFE_F00D, 2'b00);
`endif

    tick();
    tick();
    chk("queues_empty", 32'(exp_b.size() + exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
